// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined RISC core: widths, reset PC,
// opcode constants, NOP encoding and the fetch FSM state encoding.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;

    localparam logic [PC_W-1:0] RESET_PC = 8'h00;

    // Major opcodes carried in the top bits of an instruction byte.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;

    // All-zero byte doubles as the bubble placed in IF/ID after reset.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'b00,
        FS_RUN    = 2'b01,
        FS_HALTED = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: loads a fresh fetch, holds on stall, and on flush
// drops only the valid bit so the last instruction/PC stay visible.
module if_id_register
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               valid
);

    // Load takes priority; the controller never asserts load and flush together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end else if (flush) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational instruction memory
// address and feeds the IF/ID register. Start/halt FSM plus per-cycle
// redirect > stall > advance priority while running.
module instruction_fetch_unit
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               running,
    output logic               pc_wrapped
);

    // Handshake note: there is no backpressure from memory; imem_data is
    // valid in the same cycle as imem_addr. if_id_valid marks a real,
    // non-flushed fetch; stall from decode holds the whole IF/ID slot.

    localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            wrapped;
    logic            wrapped_next;

    logic            start_ok;
    logic            do_redirect;
    logic            do_advance;
    logic            if_flush;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start launches from IDLE/HALTED unless halt_req is also
    // high; halt_req leaves RUN after the current cycle's fetch.
    always_comb begin
        state_next = state;
        case (state)
            FS_IDLE, FS_HALTED: begin
                if (start && !halt_req) begin
                    state_next = FS_RUN;
                end
            end
            FS_RUN: begin
                if (halt_req) begin
                    state_next = FS_HALTED;
                end
            end
            default: state_next = FS_IDLE;
        endcase
    end

    // FSM outputs: per-cycle control decoded from state and requests.
    always_comb begin
        running     = (state == FS_RUN);
        start_ok    = (state != FS_RUN) && start && !halt_req;
        do_redirect = running && redirect;
        do_advance  = running && !redirect && !stall;
        // Outside RUN the slot drains to invalid; a redirect squashes the
        // wrong-path fetch even if decode is stalling.
        if_flush    = !running || do_redirect;
    end

    // PC and wrap flag next values.
    always_comb begin
        pc_next      = pc;
        wrapped_next = wrapped;
        if (start_ok) begin
            pc_next      = RESET_PC;
            wrapped_next = 1'b0;
        end else if (do_redirect) begin
            pc_next = redirect_pc;
        end else if (do_advance) begin
            pc_next = pc + PC_ONE;
            if (pc == PC_MAX) begin
                wrapped_next = 1'b1;
            end
        end
    end

    // PC and sticky wrap flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            wrapped <= 1'b0;
        end else begin
            pc      <= pc_next;
            wrapped <= wrapped_next;
        end
    end

    assign imem_addr  = pc;
    assign pc_wrapped = wrapped;

    if_id_register u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (do_advance),
        .flush    (if_flush),
        .instr_in (imem_data),
        .pc_in    (pc),
        .instr    (if_id_instr),
        .pc       (if_id_pc),
        .valid    (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed sequence followed by random
// control traffic, checked against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       halt_req;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] if_id_instr;
    logic [7:0] if_id_pc;
    logic       if_id_valid;
    logic       running;
    logic       pc_wrapped;

    logic [7:0] mem [256];

    int tests;
    int fails;

    // Scoreboard: {if_id_pc, if_id_instr} expected on every valid cycle.
    logic [15:0] exp_q [$];

    // Reference model state.
    bit         m_run;
    logic [7:0] m_pc;
    bit         m_wrapped;
    bit         m_valid;
    logic [7:0] m_instr;
    logic [7:0] m_ipc;

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .running     (running),
        .pc_wrapped  (pc_wrapped)
    );

    // Combinational instruction memory.
    assign imem_data = mem[imem_addr];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run     = 1'b0;
        m_pc      = 8'h00;
        m_wrapped = 1'b0;
        m_valid   = 1'b0;
        m_instr   = 8'h00;
        m_ipc     = 8'h00;
    endtask

    // One clock with the given controls; model updated from the fetch rules.
    task automatic step(input bit s, input bit h, input bit st, input bit rd, input logic [7:0] rpc);
        start       = s;
        halt_req    = h;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
        if (m_run) begin
            if (rd) begin
                m_pc    = rpc;
                m_valid = 1'b0;
            end else if (!st) begin
                m_instr = mem[m_pc];
                m_ipc   = m_pc;
                m_valid = 1'b1;
                if (m_pc == 8'hFF) m_wrapped = 1'b1;
                m_pc = m_pc + 8'd1;
            end
            if (h) m_run = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (s && !h) begin
                m_run     = 1'b1;
                m_pc      = 8'h00;
                m_wrapped = 1'b0;
            end
        end
        check("running", running, m_run);
        check("imem_addr", imem_addr, m_pc);
        check("if_id_valid", if_id_valid, m_valid);
        check("pc_wrapped", pc_wrapped, m_wrapped);
        if (m_valid) exp_q.push_back({m_ipc, m_instr});
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: every valid IF/ID cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && if_id_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL if_id_unexpected: got pc=%0h instr=%0h with nothing expected", if_id_pc, if_id_instr);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("if_id_pc_instr", {if_id_pc, if_id_instr}, e);
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h0A;
        mem[1] = 8'h33;
        mem[2] = 8'h4C;
        mem[3] = 8'h75;

        // Reset.
        rst_n = 1'b0;
        start = 0; halt_req = 0; stall = 0; redirect = 0; redirect_pc = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_running", running, 0);
        check("reset_imem_addr", imem_addr, 8'h00);
        check("reset_valid", if_id_valid, 0);
        check("reset_instr", if_id_instr, 8'h00);
        check("reset_if_id_pc", if_id_pc, 8'h00);
        check("reset_wrapped", pc_wrapped, 0);
        rst_n = 1'b1;

        // Idle: redirect/stall ignored.
        step(0, 0, 1, 1, 8'h55);
        // Start and straight-line fetch with a 2-cycle stall at PC=2.
        step(1, 0, 0, 0, 8'h00);
        advance(2);
        check("stall_addr_before", imem_addr, 8'h02);
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        advance(2);
        // Redirect with simultaneous stall.
        step(0, 0, 1, 1, 8'h40);
        advance(2);
        // Redirect near the top of memory and wrap.
        step(0, 0, 0, 1, 8'hFE);
        advance(3);
        check("wrap_flag", pc_wrapped, 1);
        // Start ignored while running.
        step(1, 0, 0, 0, 8'h00);
        // Halt: one more fetch, then frozen.
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'h20);
        step(0, 0, 0, 0, 8'h00);
        // Start and halt together while halted: stay halted.
        step(1, 1, 0, 0, 8'h00);
        // Restart from RESET_PC.
        step(1, 0, 0, 0, 8'h00);
        check("restart_pc", imem_addr, 8'h00);
        advance(2);
        // Halt together with redirect.
        step(0, 1, 0, 1, 8'h90);
        step(1, 0, 0, 0, 8'h00);

        // Random control traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 8,
                 8'($urandom_range(0, 255)));
        end

        // Make sure we are running, then assert reset between edges.
        step(1, 0, 0, 0, 8'h00);
        advance(3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_running", running, 0);
        check("async_imem_addr", imem_addr, 8'h00);
        check("async_valid", if_id_valid, 0);
        check("async_instr", if_id_instr, 8'h00);
        check("async_if_id_pc", if_id_pc, 8'h00);
        check("async_wrapped", pc_wrapped, 0);
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0, 0, 8'h00);
        advance(4);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
